counter_multi_channel: RTL and testbench

- Single-clock, parametrised successor to the fixed 4-bit dual counter.
- Provides NUM_CH independent WIDTH-bit counters.
- Each channel has enable, up/down direction, synchronous parallel load, and a programmable terminal value.
- Each channel has a wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as a generic event/timer counter bank in the simple_registers benchmarks.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_channel.sv | 73 +++++++
 rtl/counter_multi_channel.sv | 41 ++++
 tb/tb_counter_multi_channel.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the multi-channel counter bank.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Out-of-range load values are pinned to the upper count bound.
  function automatic int unsigned clamp_load(int unsigned val, int unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter with load, programmable bound, wrap/saturate mode,
// terminal-count pulse and sticky overflow flag.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 2**WIDTH-1,
  parameter int unsigned SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam bit               SatMode = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             bound_evt;

  always_comb begin
    count_d   = count_q;
    bound_evt = 1'b0;
    if (load) begin
      count_d = WIDTH'(clamp_load(32'(load_val), MAX_COUNT));
    end else if (en) begin
      if (up) begin
        if (count_q >= MaxVal) begin
          bound_evt = 1'b1;
          count_d   = SatMode ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          bound_evt = 1'b1;
          count_d   = SatMode ? count_q : MaxVal;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d = bound_evt;
    // A new boundary event beats a simultaneous clear.
    ovf_d = bound_evt ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/counter_multi_channel.sv
// Bank of NUM_CH independent counters sharing one clock and reset.
module counter_multi_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MAX_COUNT = 2**WIDTH-1,
  parameter int unsigned SATURATE  = MODE_WRAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       clr_ovf,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .up       (up[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .clr_ovf  (clr_ovf[i]),
      .q        (q[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .ovf      (ovf[i])
    );
  end

endmodule

// File: tb/tb_counter_multi_channel.sv
// Scoreboard bench: three counter banks (wrap/15, saturate/15, wrap/9).
module tb_counter_multi_channel;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0] en_a = '0, up_a = '0, load_a = '0, clr_a = '0, tc_a, ovf_a;
  logic [7:0] lv_a = '0, q_a;
  logic [1:0] en_b = '0, up_b = '0, load_b = '0, clr_b = '0, tc_b, ovf_b;
  logic [7:0] lv_b = '0, q_b;
  logic [1:0] en_c = '0, up_c = '0, load_c = '0, clr_c = '0, tc_c, ovf_c;
  logic [7:0] lv_c = '0, q_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         inst;
    string      name;
    logic [7:0] q;
    logic [1:0] tc;
    logic [1:0] ovf;
  } exp_t;

  typedef struct {
    logic [7:0] q;
    logic [1:0] tc;
    logic [1:0] ovf;
  } obs_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  counter_multi_channel #(.WIDTH(4), .NUM_CH(2), .MAX_COUNT(15), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
    .clr_ovf(clr_a), .q(q_a), .tc(tc_a), .ovf(ovf_a)
  );

  counter_multi_channel #(.WIDTH(4), .NUM_CH(2), .MAX_COUNT(15), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .clr_ovf(clr_b), .q(q_b), .tc(tc_b), .ovf(ovf_b)
  );

  counter_multi_channel #(.WIDTH(4), .NUM_CH(2), .MAX_COUNT(9), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(load_c), .load_val(lv_c),
    .clr_ovf(clr_c), .q(q_c), .tc(tc_c), .ovf(ovf_c)
  );

  function automatic void push(int inst, string name, logic [7:0] q, logic [1:0] tc,
                               logic [1:0] ovf);
    exp_t e;
    e.inst = inst; e.name = name; e.q = q; e.tc = tc; e.ovf = ovf;
    sb.push_back(e);
  endfunction

  function automatic obs_t observe(int inst);
    obs_t o;
    case (inst)
      0:       begin o.q = q_a; o.tc = tc_a; o.ovf = ovf_a; end
      1:       begin o.q = q_b; o.tc = tc_b; o.ovf = ovf_b; end
      default: begin o.q = q_c; o.tc = tc_c; o.ovf = ovf_c; end
    endcase
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    rst = 1'b0;
    push(0, "reset_a", 8'h00, 2'b00, 2'b00);
    push(1, "reset_b", 8'h00, 2'b00, 2'b00);
    push(2, "reset_c", 8'h00, 2'b00, 2'b00);
    for (int step = 0; step < 12; step++) begin
      if (step == 1) begin rst = 1'b1; en_a = 2'b01; up_a = 2'b01; end
      if (step >= 1 && step <= 7) push(0, "run_up", 8'(step), 2'b00, 2'b00);
      if (step == 8) begin rst = 1'b0; push(0, "mid_reset", 8'h00, 2'b00, 2'b00); end
      if (step >= 9 && step <= 10) begin
        rst = 1'b1;
        push(0, "resume", 8'(step - 8), 2'b00, 2'b00);
      end
      if (step == 11) begin en_a = 2'b00; push(0, "idle_hold", 8'h02, 2'b00, 2'b00); end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.inst);
        checks++;
        if (o.q !== e.q) begin errors++; $display("FAIL %s q: got %h want %h", e.name, o.q, e.q); end
        checks++;
        if (o.tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b want %b", e.name, o.tc, e.tc); end
        checks++;
        if (o.ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", e.name, o.ovf, e.ovf); end
      end
    end
  endtask

  task automatic test_wrap_up();
    exp_t e;
    obs_t o;
    for (int step = 0; step < 7; step++) begin
      load_a = 2'b00; en_a = 2'b00; up_a = 2'b00; clr_a = 2'b00;
      case (step)
        0: begin load_a = 2'b01; lv_a = 8'h0E; push(0, "wrap_load", 8'h0E, 2'b00, 2'b00); end
        1: begin en_a = 2'b01; up_a = 2'b01; push(0, "wrap_15", 8'h0F, 2'b00, 2'b00); end
        2: begin en_a = 2'b01; up_a = 2'b01; push(0, "wrap_0", 8'h00, 2'b01, 2'b01); end
        3: begin en_a = 2'b01; up_a = 2'b01; push(0, "wrap_1", 8'h01, 2'b00, 2'b01); end
        4: push(0, "ovf_sticky", 8'h01, 2'b00, 2'b01);
        5: begin clr_a = 2'b01; push(0, "ovf_clear", 8'h01, 2'b00, 2'b00); end
        default: push(0, "ovf_stays_clr", 8'h01, 2'b00, 2'b00);
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.inst);
        checks++;
        if (o.q !== e.q) begin errors++; $display("FAIL %s q: got %h want %h", e.name, o.q, e.q); end
        checks++;
        if (o.tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b want %b", e.name, o.tc, e.tc); end
        checks++;
        if (o.ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", e.name, o.ovf, e.ovf); end
      end
    end
    clr_a = 2'b00;
  endtask

  // ch0 saturates at 0 counting down, ch1 is pinned at 15 counting up.
  task automatic test_sat_down();
    exp_t e;
    obs_t o;
    for (int step = 0; step < 6; step++) begin
      load_b = 2'b00; en_b = 2'b11; up_b = 2'b10; clr_b = 2'b00;
      case (step)
        0: begin
          load_b = 2'b11; lv_b = 8'hF1; en_b = 2'b00;
          push(1, "sat_load", 8'hF1, 2'b00, 2'b00);
        end
        1: push(1, "sat_edge1", 8'hF0, 2'b10, 2'b10);
        2: push(1, "sat_edge2", 8'hF0, 2'b11, 2'b11);
        3: begin clr_b = 2'b01; push(1, "sat_set_wins", 8'hF0, 2'b11, 2'b11); end
        4: push(1, "sat_edge4", 8'hF0, 2'b11, 2'b11);
        default: begin
          en_b = 2'b00; clr_b = 2'b11;
          push(1, "sat_clear", 8'hF0, 2'b00, 2'b00);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.inst);
        checks++;
        if (o.q !== e.q) begin errors++; $display("FAIL %s q: got %h want %h", e.name, o.q, e.q); end
        checks++;
        if (o.tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b want %b", e.name, o.tc, e.tc); end
        checks++;
        if (o.ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", e.name, o.ovf, e.ovf); end
      end
    end
    en_b = 2'b00; clr_b = 2'b00;
  endtask

  task automatic test_modulo();
    exp_t e;
    obs_t o;
    for (int step = 0; step < 4; step++) begin
      load_c = 2'b00; en_c = 2'b00; up_c = 2'b00;
      case (step)
        0: begin load_c = 2'b11; lv_c = 8'hFC; push(2, "mod_clamp", 8'h99, 2'b00, 2'b00); end
        1: begin en_c = 2'b01; up_c = 2'b01; push(2, "mod_up_wrap", 8'h90, 2'b01, 2'b01); end
        2: begin en_c = 2'b01; push(2, "mod_down_wrap", 8'h99, 2'b01, 2'b01); end
        default: begin en_c = 2'b01; push(2, "mod_down", 8'h98, 2'b00, 2'b01); end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.inst);
        checks++;
        if (o.q !== e.q) begin errors++; $display("FAIL %s q: got %h want %h", e.name, o.q, e.q); end
        checks++;
        if (o.tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b want %b", e.name, o.tc, e.tc); end
        checks++;
        if (o.ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", e.name, o.ovf, e.ovf); end
      end
    end
    en_c = 2'b00;
  endtask

  task automatic test_priority();
    exp_t e;
    obs_t o;
    for (int step = 0; step < 4; step++) begin
      load_a = 2'b00; en_a = 2'b00; up_a = 2'b00;
      case (step)
        0: begin load_a = 2'b10; lv_a = 8'h30; push(0, "prio_setup", 8'h31, 2'b00, 2'b00); end
        1: begin
          load_a = 2'b01; en_a = 2'b11; up_a = 2'b11; lv_a = 8'hF5;
          push(0, "load_beats_en", 8'h45, 2'b00, 2'b00);
        end
        default: push(0, "prio_hold", 8'h45, 2'b00, 2'b00);
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.inst);
        checks++;
        if (o.q !== e.q) begin errors++; $display("FAIL %s q: got %h want %h", e.name, o.q, e.q); end
        checks++;
        if (o.tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b want %b", e.name, o.tc, e.tc); end
        checks++;
        if (o.ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", e.name, o.ovf, e.ovf); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_modulo();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
